// File: rtl/keypad_debouncer.sv
// Multi-channel key debouncer: synchronises active-low key lines, filters contact
// bounce per channel, and emits levels, press/release pulses, auto-repeat and a key event.
module keypad_debouncer #(
   parameter int CHANNELS      = 10,
   parameter int STABLE_CYCLES = 4,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 3,
   parameter int IDX_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] keys_n,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_pressed,
   output logic                key_valid,
   output logic [IDX_W-1:0]    key_index
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   logic [CHANNELS-1:0] s1_q, s1_d;
   logic [CHANNELS-1:0] s2_q, s2_d;
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] release_q, release_d;
   logic [CHANNELS-1:0] rep_fire;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   always_comb begin
      s1_d    = ~keys_n;
      s2_d    = s1_q;
      level_d = level_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         // Any sample agreeing with the current level restarts the stability window.
         if (s2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_W'(STABLE_CYCLES - 1)) begin
               level_d[i] = ~level_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // rep_fire is only ever set while the level stays high, so it cannot meet a release.
   always_comb begin
      press_d   = (level_d & ~level_q) | rep_fire;
      release_d = ~level_d & level_q;
   end

   generate
      if (REPEAT_EN != 0) begin : g_rep
         localparam int REP_MAX = REPEAT_DELAY + REPEAT_PERIOD - 1;
         localparam int REP_W   = $clog2(REP_MAX + 1);

         logic [REP_W-1:0] rep_q [CHANNELS];
         logic [REP_W-1:0] rep_d [CHANNELS];

         always_comb begin
            rep_fire = '0;
            for (int i = 0; i < CHANNELS; i++) begin
               rep_d[i] = '0;
               if (level_q[i] && level_d[i]) begin
                  // Wrap back to the first-repeat point so long holds never overflow.
                  if (rep_q[i] == REP_W'(REP_MAX)) begin
                     rep_d[i] = REP_W'(REPEAT_DELAY);
                  end else begin
                     rep_d[i] = rep_q[i] + 1'b1;
                  end
                  if ((rep_q[i] == REP_W'(REPEAT_DELAY - 1)) ||
                      (rep_q[i] == REP_W'(REP_MAX))) begin
                     rep_fire[i] = 1'b1;
                  end
               end
            end
         end

         always_ff @(posedge clk) begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (rst) begin
                  rep_q[i] <= '0;
               end else begin
                  rep_q[i] <= rep_d[i];
               end
            end
         end
      end else begin : g_norep
         assign rep_fire = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Lowest-index press wins the encoded event.
   always_comb begin
      key_valid = |press_q;
      key_index = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (press_q[i]) begin
            key_index = IDX_W'(i);
         end
      end
   end

   assign level_out     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign any_pressed   = |level_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer: the driver pushes expected outputs from a
// window/age reference model, and a monitor pops and compares them every cycle.
module tb_keypad_debouncer;

   localparam int CH = 4;
   localparam int ST = 4;
   localparam int RD = 8;
   localparam int RP = 3;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] keys_n = '1;
   logic [CH-1:0] level_out, press_pulse, release_pulse;
   logic          any_pressed, key_valid;
   logic [IW-1:0] key_index;

   keypad_debouncer #(
      .CHANNELS(CH), .STABLE_CYCLES(ST), .REPEAT_EN(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .keys_n(keys_n),
      .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .any_pressed(any_pressed), .key_valid(key_valid), .key_index(key_index)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0] lvl;
      logic [CH-1:0] pp;
      logic [CH-1:0] rp;
      logic          any;
      logic          kv;
      logic [IW-1:0] idx;
      logic          chk_idx;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: raw samples reach the comparator two edges late; a level flips
   // once the last ST samples all disagree with it; repeats fire at hold ages RD, RD+RP, ...
   bit m_lvl  [CH];
   bit m_p0   [CH];
   bit m_p1   [CH];
   bit m_hist [CH][ST];
   int m_nh   [CH];
   int m_age  [CH];

   task automatic model_step(input logic r, input logic [CH-1:0] k);
      exp_t e;
      bit   samp, all_diff;
      e.pp = '0;
      e.rp = '0;
      for (int c = 0; c < CH; c++) begin
         if (r) begin
            m_lvl[c] = 0; m_p0[c] = 0; m_p1[c] = 0; m_nh[c] = 0; m_age[c] = 0;
         end else begin
            samp    = m_p1[c];
            m_p1[c] = m_p0[c];
            m_p0[c] = ~k[c];
            for (int j = ST - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
            m_hist[c][0] = samp;
            if (m_nh[c] < ST) m_nh[c]++;
            all_diff = (m_nh[c] == ST);
            for (int j = 0; j < ST; j++) if (m_hist[c][j] == m_lvl[c]) all_diff = 0;
            if (all_diff) begin
               m_lvl[c] = ~m_lvl[c];
               m_nh[c]  = 0;
               if (m_lvl[c]) begin
                  e.pp[c]  = 1'b1;
                  m_age[c] = 0;
               end else begin
                  e.rp[c] = 1'b1;
               end
            end else if (m_lvl[c]) begin
               m_age[c]++;
               if (m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0) e.pp[c] = 1'b1;
            end
         end
         e.lvl[c] = m_lvl[c];
      end
      e.any = |e.lvl;
      e.kv  = |e.pp;
      e.idx = '0;
      for (int c = CH - 1; c >= 0; c--) if (e.pp[c]) e.idx = IW'(c);
      e.chk_idx = e.kv | r;
      exp_q.push_back(e);
   endtask

   task automatic apply(input logic r, input logic [CH-1:0] k, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst    = r;
         keys_n = k;
         model_step(r, k);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("level_out", 32'(level_out), 32'(e.lvl));
            chk("press_pulse", 32'(press_pulse), 32'(e.pp));
            chk("release_pulse", 32'(release_pulse), 32'(e.rp));
            chk("any_pressed", 32'(any_pressed), 32'(e.any));
            chk("key_valid", 32'(key_valid), 32'(e.kv));
            if (e.chk_idx) chk("key_index", 32'(key_index), 32'(e.idx));
         end
      end
   end

   initial begin : driver
      logic [CH-1:0] k;
      // reset and idle
      apply(1'b1, 4'b1111, 3);
      apply(1'b0, 4'b1111, 20);
      // clean press and release on channel 2
      apply(1'b0, 4'b1011, 7);
      apply(1'b0, 4'b1111, 10);
      // bounce on channel 0, then a real press
      apply(1'b0, 4'b1110, 3);
      apply(1'b0, 4'b1111, 1);
      apply(1'b0, 4'b1110, 2);
      apply(1'b0, 4'b1111, 8);
      apply(1'b0, 4'b1110, 6);
      apply(1'b0, 4'b1111, 10);
      // simultaneous press on channels 1 and 3
      apply(1'b0, 4'b0101, 8);
      apply(1'b0, 4'b1111, 10);
      // long hold on channel 3 for auto-repeat
      apply(1'b0, 4'b0111, 30);
      apply(1'b0, 4'b1111, 12);
      // reset mid-count while channel 1 stays held
      apply(1'b0, 4'b1101, 4);
      apply(1'b1, 4'b1101, 1);
      apply(1'b0, 4'b1101, 15);
      apply(1'b0, 4'b1111, 10);
      // reset mid-repeat
      apply(1'b0, 4'b1110, 16);
      apply(1'b1, 4'b1110, 1);
      apply(1'b0, 4'b1111, 10);
      // random bounce, holds and occasional reset
      k = '1;
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 5) == 0) k[c] = ~k[c];
         end
         apply(($urandom_range(0, 149) == 0), k, 1);
      end
      // long random holds so repeat wrap is exercised
      for (int n = 0; n < 20; n++) begin
         k = CH'($urandom_range(0, 15));
         apply(1'b0, k, $urandom_range(1, 25));
      end
      apply(1'b0, 4'b1111, 12);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #3;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
